body_scan_reader: RTL and testbench
===================================

# body_scan_reader

Read side of the body-segment position stack: once per scan line, during horizontal blanking, walks the 64-entry segment X/Y store through its read port and captures the segments that intersect the next line into a double-buffered hit list. During active video it compares the pixel counters against that list and drives registered `body_on` / `head_on` pixel flags to the VGA colour mux. It sits between the segment stack (writer, updated on `move_clock`) and the pixel output stage, in the `VGA_CLK` domain.

## Interface
- `SEG_COUNT`, 64: stack entries; entry 0 is the head.
- `COORD_W`, 12: coordinate width, matches `CounterX`/`CounterY`.
- `SEG_SIZE`, 10: segment square edge in pixels.
- `HIT_SLOTS`, 8: maximum non-head segments captured per line.
- `H_ACTIVE`, 640 / `H_TOTAL`, 800 / `V_TOTAL`, 525: raster geometry.

- `VGA_CLK`  in  1  pixel clock; the only clock.
- `reset`  in  1  synchronous, active-low (reset when 0).
- `start`  in  1  game running; low forces idle and blank output.
- `CounterX`  in  COORD_W  current pixel column.
- `CounterY`  in  COORD_W  current pixel row.
- `rd_en`  out  1  stack read strobe.
- `rd_addr`  out  6  stack entry index.
- `rd_x`, `rd_y`  in  COORD_W each  entry data, valid one cycle after `rd_en`.
- `body_on`  out  1  pixel covered by any segment.
- `head_on`  out  1  pixel covered by entry 0.
- `scan_busy`  out  1  FSM in SCAN.
- `overflow`  out  1  sticky hit-list overflow (see Configuration).

## Operation
- Reset or `start`=0: FSM→IDLE; both hit buffers cleared (all slots and head invalid); `rd_en`, `rd_addr`, `body_on`, `head_on`, `scan_busy`, `overflow` = 0.
- States: IDLE → SCAN when `CounterX == H_ACTIVE`; SCAN → DONE after last compare; DONE → IDLE at swap.
- Target line T = `CounterY`+1, wrapping to 0 when `CounterY == V_TOTAL-1`; latched on SCAN entry.
- SCAN: `rd_addr` steps 0..SEG_COUNT-1, one per cycle, `rd_en`=1. Each returned entry hits if T ≥ `rd_y` and T < `rd_y`+SEG_SIZE; compare done at COORD_W+1 bits (no wrap). Off-screen sentinel Y (720) never hits for T < V_TOTAL.
- Entry 0 hit → head slot of back buffer (X stored, valid set). Other hits → next free slot in ascending index order; hit with all HIT_SLOTS full is dropped and sets the overflow condition.
- Swap at `CounterX == H_TOTAL-1`: back buffer → front, back cleared. Swap while still in SCAN (guard only) swaps the partial list, sets overflow condition, returns to IDLE.
- Active pixel (`CounterX` < H_ACTIVE): `head_on` = head valid ∧ hx ≤ `CounterX` < hx+SEG_SIZE; `body_on` = `head_on` ∨ any valid slot matching likewise. Both 0 outside active columns.

## Timing
- SCAN duration: SEG_COUNT+1 cycles (65) from trigger; fits inside 160-cycle blanking.
- `rd_addr` = k on trigger+k; data for k compared at trigger+k+1.
- Pixel flags registered: `CounterX`=x at cycle n → flags for x at n+1.
- `start` falling or `reset` low mid-SCAN: IDLE next cycle, buffers cleared, `rd_en`=0 next cycle.
- Stack rewrite during SCAN: no tearing protection; mixed old/new entries acceptable for one line.

## Configuration
- `BODY_SCAN_OVERFLOW_EN`: defined → `overflow` is sticky, set by any dropped hit or late swap, cleared only by reset or `start`=0. Undefined → overflow logic removed, `overflow` tied 0; drop behaviour unchanged.

## Structure
- Shared package `pong_pkg`: `COORD_W`, raster constants, `SEG_SIZE`, off-screen sentinel (720), FSM state enum.
- One sub-module `seg_hit_list`: HIT_SLOTS+head slot double buffer with insert, swap, clear and per-pixel match; FSM and read sequencing stay in the top.

## Test plan
- Head at (100,205), all others Y=720; raster lines 204–216 → `head_on`=`body_on`=1 exactly for X 100–109 on rows 205–214, one cycle after the counter.
- 10 segments all at Y=300, X=0,20..180 → first 8 non-head slots shown on rows 300–309, last one absent, `overflow`=1 with macro, 0 without.
- Trigger at `CounterX`=640 → `rd_addr` 0..63 on consecutive cycles, `scan_busy` high 65 cycles, `rd_en` low after.
- `CounterY`=524 scan, segment at Y=0 → visible on row 0 (target wrap).
- `reset`=0 at scan cycle 30 → next cycle IDLE, `rd_en`=0, flags 0, following line blank until a fresh scan.
- Segment at X=635 → `body_on` for X 635–639 only, 0 in blanking.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared raster geometry, segment constants and scan FSM states
package pong_pkg;
  localparam int COORD_W     = 12;
  localparam int H_ACTIVE    = 640;
  localparam int H_TOTAL     = 800;
  localparam int V_TOTAL     = 525;
  localparam int SEG_SIZE    = 10;
  localparam int SEG_COUNT   = 64;
  localparam int HIT_SLOTS   = 8;
  localparam int OFFSCREEN_Y = 720;
  localparam int ADDR_W      = $clog2(SEG_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} scan_state_t;

  // v inside [lo, lo+SEG_SIZE); one extra bit so a span near the top never wraps
  function automatic logic in_span(input logic [COORD_W-1:0] lo, input logic [COORD_W-1:0] v);
    logic [COORD_W:0] lo_e, v_e;
    lo_e = {1'b0, lo};
    v_e  = {1'b0, v};
    return (v_e >= lo_e) && (v_e < lo_e + (COORD_W+1)'(SEG_SIZE));
  endfunction
endpackage

// File: rtl/body_scan_reader_if.sv
// rtl/body_scan_reader_if.sv - segment stack read port (reader is master, stack is slave)
interface body_scan_reader_if;
  import pong_pkg::*;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;

  modport master (output rd_en, rd_addr, input rd_x, rd_y);
  modport slave  (input rd_en, rd_addr, output rd_x, rd_y);
endinterface

// File: rtl/seg_hit_list.sv
// rtl/seg_hit_list.sv - double-buffered head + HIT_SLOTS hit list with per-pixel match
module seg_hit_list
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               clear,
  input  logic               insert,
  input  logic               insert_head,
  input  logic [COORD_W-1:0] insert_x,
  input  logic               swap,
  input  logic [COORD_W-1:0] pix_x,
  output logic               head_match,
  output logic               slot_match,
  output logic               drop
);
  localparam int N_W = $clog2(HIT_SLOTS + 1);
  localparam int I_W = $clog2(HIT_SLOTS);

  logic [COORD_W-1:0] back_x  [HIT_SLOTS];
  logic [COORD_W-1:0] front_x [HIT_SLOTS];
  logic [COORD_W-1:0] back_hx, front_hx;
  logic               back_hv, front_hv;
  logic [N_W-1:0]     back_n, front_n;
  logic               full;

  assign full = back_n == N_W'(HIT_SLOTS);
  assign drop = insert && !insert_head && full;

  always_ff @(posedge clk) begin
    if (clear) begin
      back_n   <= '0;
      front_n  <= '0;
      back_hv  <= 1'b0;
      front_hv <= 1'b0;
    end else if (swap) begin
      front_x  <= back_x;
      front_hx <= back_hx;
      front_hv <= back_hv;
      front_n  <= back_n;
      back_n   <= '0;
      back_hv  <= 1'b0;
    end else if (insert) begin
      if (insert_head) begin
        back_hx <= insert_x;
        back_hv <= 1'b1;
      end else if (!full) begin
        back_x[back_n[I_W-1:0]] <= insert_x;
        back_n                  <= back_n + N_W'(1);
      end
    end
  end

  // slots fill from 0 upward, so slot i is live exactly when i < front_n
  always_comb begin
    slot_match = 1'b0;
    for (int i = 0; i < HIT_SLOTS; i++)
      if (N_W'(i) < front_n && in_span(front_x[i], pix_x)) slot_match = 1'b1;
  end

  assign head_match = front_hv && in_span(front_hx, pix_x);
endmodule

// File: rtl/body_scan_reader.sv
// rtl/body_scan_reader.sv - blanking-time segment scan into a hit list, registered body/head pixel flags
// BODY_SCAN_OVERFLOW_EN: when defined, overflow is a sticky flag for dropped hits and late swaps
module body_scan_reader
  import pong_pkg::*;
(
  input  logic               VGA_CLK,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] CounterX,
  input  logic [COORD_W-1:0] CounterY,
  body_scan_reader_if.master stk,
  output logic               body_on,
  output logic               head_on,
  output logic               scan_busy,
  output logic               overflow
);
  localparam int CNT_W = ADDR_W + 1;

  scan_state_t        state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [COORD_W-1:0] target;
  logic               cmp_valid;
  logic [ADDR_W-1:0]  cmp_idx;
  logic clear, trigger, swap, active, last_cmp, late_swap;
  logic hit, insert, drop, head_match, slot_match;

  assign clear     = !reset || !start;
  assign trigger   = CounterX == COORD_W'(H_ACTIVE);
  assign swap      = CounterX == COORD_W'(H_TOTAL - 1);
  assign active    = CounterX < COORD_W'(H_ACTIVE);
  assign last_cmp  = cnt == CNT_W'(SEG_COUNT);
  assign late_swap = swap && state == S_SCAN;
  assign hit       = in_span(stk.rd_y, target);
  // the swap owns the back buffer on its cycle; a compare landing there is lost
  assign insert    = cmp_valid && state == S_SCAN && hit && !swap;

  always_ff @(posedge VGA_CLK) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trigger) state_nxt = S_SCAN;
      S_SCAN:  if (swap) state_nxt = S_IDLE;
               else if (last_cmp) state_nxt = S_DONE;
      S_DONE:  if (swap) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    scan_busy   = state == S_SCAN;
    stk.rd_en   = scan_busy && cnt < CNT_W'(SEG_COUNT);
    stk.rd_addr = stk.rd_en ? cnt[ADDR_W-1:0] : '0;
  end

  always_ff @(posedge VGA_CLK) begin
    if (clear) begin
      cnt       <= '0;
      target    <= '0;
      cmp_valid <= 1'b0;
      cmp_idx   <= '0;
    end else begin
      cmp_valid <= stk.rd_en;
      cmp_idx   <= stk.rd_addr;
      if (state == S_IDLE && trigger) begin
        cnt    <= '0;
        target <= (CounterY == COORD_W'(V_TOTAL - 1)) ? '0 : CounterY + COORD_W'(1);
      end else if (state == S_SCAN) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  seg_hit_list u_hits (
    .clk         (VGA_CLK),
    .clear       (clear),
    .insert      (insert),
    .insert_head (cmp_idx == '0),
    .insert_x    (stk.rd_x),
    .swap        (swap),
    .pix_x       (CounterX),
    .head_match  (head_match),
    .slot_match  (slot_match),
    .drop        (drop)
  );

  always_ff @(posedge VGA_CLK) begin
    if (clear) begin
      head_on <= 1'b0;
      body_on <= 1'b0;
    end else begin
      head_on <= active && head_match;
      body_on <= active && (head_match || slot_match);
    end
  end

`ifdef BODY_SCAN_OVERFLOW_EN
  logic ovf_q;
  always_ff @(posedge VGA_CLK) begin
    if (clear)                  ovf_q <= 1'b0;
    else if (drop || late_swap) ovf_q <= 1'b1;
  end
  assign overflow = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = drop | late_swap;
  assign overflow   = 1'b0;
`endif
endmodule

// File: tb/tb_body_scan_reader.sv
// tb/tb_body_scan_reader.sv - self-checking bench for body_scan_reader against a per-line segment model
module tb_body_scan_reader;
  import pong_pkg::*;

  logic VGA_CLK = 1'b0;
  always #5 VGA_CLK = ~VGA_CLK;

  logic               reset, start;
  logic [COORD_W-1:0] CounterX, CounterY;
  logic               body_on, head_on, scan_busy, overflow;

  body_scan_reader_if bif ();

  body_scan_reader dut (
    .VGA_CLK   (VGA_CLK),
    .reset     (reset),
    .start     (start),
    .CounterX  (CounterX),
    .CounterY  (CounterY),
    .stk       (bif),
    .body_on   (body_on),
    .head_on   (head_on),
    .scan_busy (scan_busy),
    .overflow  (overflow)
  );

  int seg_x [SEG_COUNT];
  int seg_y [SEG_COUNT];
  int n_cmp = 0;
  int n_bad = 0;

  // model of what is on screen: head, up to HIT_SLOTS body X positions, sticky drop flag
  bit m_hv;
  int m_hx;
  int m_slots[$];
  bit m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit covers(input int lo, input int v);
    return v >= lo && v < lo + SEG_SIZE;
  endfunction

  function automatic bit exp_head(input int x);
    return x < H_ACTIVE && m_hv && covers(m_hx, x);
  endfunction

  function automatic bit exp_body(input int x);
    bit b;
    b = exp_head(x);
    foreach (m_slots[i]) if (x < H_ACTIVE && covers(m_slots[i], x)) b = 1'b1;
    return b;
  endfunction

  task automatic model_clear();
    m_hv = 1'b0;
    m_slots.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_scan(input int t);
    m_hv = covers(seg_y[0], t);
    m_hx = seg_x[0];
    m_slots.delete();
    for (int i = 1; i < SEG_COUNT; i++)
      if (covers(seg_y[i], t)) begin
        if (m_slots.size() < HIT_SLOTS) m_slots.push_back(seg_x[i]);
        else m_ovf = 1'b1;
      end
  endtask

  function automatic int first_diff(input logic [H_TOTAL-1:0] a, input logic [H_TOTAL-1:0] b);
    for (int i = 0; i < H_TOTAL; i++) if (a[i] !== b[i]) return i;
    return 0;
  endfunction

  task automatic clear_segs();
    for (int i = 0; i < SEG_COUNT; i++) begin
      seg_x[i] = $urandom_range(0, H_ACTIVE - 1);
      seg_y[i] = OFFSCREEN_Y;
    end
  endtask

  // one pixel clock; the stack model answers a read one cycle after rd_en
  task automatic step();
    logic              pe;
    logic [ADDR_W-1:0] pa;
    pe = bif.rd_en;
    pa = bif.rd_addr;
    @(posedge VGA_CLK);
    #1;
    if (pe === 1'b1) begin
      bif.rd_x = COORD_W'(seg_x[pa]);
      bif.rd_y = COORD_W'(seg_y[pa]);
    end
  endtask

  task automatic run_line(input int y, input int rst_at);
    logic [H_TOTAL-1:0] ob, oh, eb, eh;
    int busy, en, addr_bad, c;
    busy = 0; en = 0; addr_bad = 0;
    for (int x = 0; x < H_TOTAL; x++) begin
      CounterX = COORD_W'(x);
      CounterY = COORD_W'(y);
      if (x == rst_at) begin
        reset = 1'b0;
        model_clear();
      end
      eb[x] = (x == rst_at) ? 1'b0 : exp_body(x);
      eh[x] = (x == rst_at) ? 1'b0 : exp_head(x);
      step();
      ob[x] = body_on;
      oh[x] = head_on;
      if (scan_busy === 1'b1) busy++;
      if (bif.rd_en === 1'b1) begin
        en++;
        if (bif.rd_addr !== ADDR_W'(x - H_ACTIVE)) addr_bad++;
      end
      if (x == rst_at) begin
        check("rst_mid_rd_en", bif.rd_en, 0);
        check("rst_mid_scan_busy", scan_busy, 0);
        check("rst_mid_flags", {body_on, head_on}, 0);
        reset = 1'b1;
      end
    end
    if (rst_at < 0) begin
      check("scan_busy_cycles", busy, SEG_COUNT + 1);
      check("rd_en_cycles", en, SEG_COUNT);
      check("rd_addr_seq_errors", addr_bad, 0);
      model_scan(y == V_TOTAL - 1 ? 0 : y + 1);
    end
    c = first_diff(ob, eb);
    assert (ob === eb) else begin
      n_bad++;
      $error("FAIL body_on row=%0d col=%0d observed=%b expected=%b", y, c, ob[c], eb[c]);
    end
    n_cmp++;
    c = first_diff(oh, eh);
    assert (oh === eh) else begin
      n_bad++;
      $error("FAIL head_on row=%0d col=%0d observed=%b expected=%b", y, c, oh[c], eh[c]);
    end
    n_cmp++;
`ifdef BODY_SCAN_OVERFLOW_EN
    check("overflow", overflow, m_ovf);
`else
    check("overflow", overflow, 0);
`endif
  endtask

  initial begin
    int r;
    reset = 1'b0; start = 1'b0;
    CounterX = '0; CounterY = '0;
    bif.rd_x = '0; bif.rd_y = '0;
    clear_segs();
    repeat (3) step();
    check("reset_rd_en", bif.rd_en, 0);
    check("reset_rd_addr", bif.rd_addr, 0);
    check("reset_body_on", body_on, 0);
    check("reset_head_on", head_on, 0);
    check("reset_scan_busy", scan_busy, 0);
    check("reset_overflow", overflow, 0);
    reset = 1'b1; start = 1'b1;
    model_clear();

    // head alone at (100,205)
    clear_segs();
    seg_x[0] = 100; seg_y[0] = 205;
    for (int y = 203; y <= 216; y++) run_line(y, -1);

    // ten segments on one row: head plus nine bodies, the ninth body is dropped
    clear_segs();
    for (int i = 0; i < 10; i++) begin
      seg_x[i] = 20 * i;
      seg_y[i] = 300;
    end
    for (int y = 299; y <= 310; y++) run_line(y, -1);

    // target line wraps from the last raster line to row 0
    clear_segs();
    seg_x[5] = 300; seg_y[5] = 0;
    run_line(V_TOTAL - 1, -1);
    run_line(0, -1);

    // body segment straddling the right edge of the active area
    clear_segs();
    seg_x[3] = 635; seg_y[3] = 100;
    run_line(99, -1);
    run_line(100, -1);

    // random segment clouds around a random row
    for (int k = 0; k < 5; k++) begin
      r = $urandom_range(12, 500);
      for (int i = 0; i < SEG_COUNT; i++) begin
        seg_x[i] = $urandom_range(0, H_ACTIVE + 5);
        seg_y[i] = ($urandom_range(0, 3) == 0) ? OFFSCREEN_Y : $urandom_range(r - 12, r + 2);
      end
      for (int y = r - 1; y <= r + 1; y++) run_line(y, -1);
    end

    // reset dropped at scan cycle 30, following line must be blank
    clear_segs();
    seg_x[0] = 100; seg_y[0] = 205;
    run_line(209, -1);
    run_line(210, H_ACTIVE + 30);
    run_line(211, -1);
    run_line(212, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
